para_bus_sync: RTL and testbench

Clocked, parametrised DSP parallel-bus slave that replaces the strobe-edge-driven register interface. It samples the asynchronous DSP WR/RD/CS0 strobes into the FPGA clock domain. It exposes writable control/LED registers and read-only incremental (32-bit, two-word) and absolute (16-bit) encoder channels. Multi-word reads are atomic via a shadow latch. It sits between the DSP external memory interface pins and the encoder front-end blocks.

---
 rtl/para_bus_pkg.sv | 23 ++
 rtl/para_bus_sync_strobe_sync.sv | 26 ++
 rtl/para_bus_sync.sv | 195 +++++++++++++++++++
 tb/tb_para_bus_sync.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/para_bus_pkg.sv
// Shared definitions for the DSP parallel-bus slave: register map, FSM states
// and status bit positions.
package para_bus_pkg;

   localparam int unsigned CONTROL_ADD = 32'h00;
   localparam int unsigned LED_ADD     = 32'h01;
   localparam int unsigned STATUS_ADD  = 32'h02;
   localparam int unsigned INC_LO_BASE = 32'h10;
   localparam int unsigned INC_HI_BASE = 32'h18;
   localparam int unsigned ABS_BASE    = 32'h20;

   localparam int unsigned INC_SLOTS = 8;
   localparam int unsigned ABS_SLOTS = 16;

   localparam int STATUS_COLLISION_BIT = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } busState_t;

endpackage

// File: rtl/para_bus_sync_strobe_sync.sv
// Three-flop synchroniser for one active-low DSP strobe, with single-cycle
// rise/fall pulses taken between the second and third stages.
module strobe_sync
   import para_bus_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic strobeN,
   output logic strobeS,
   output logic fall,
   output logic rise
);

   logic [2:0] stageReg;

   // Flops reset to 1 so an idle (high) strobe never produces a spurious edge.
   always_ff @(posedge clk) begin
      if (!rst_n) stageReg <= 3'b111;
      else        stageReg <= {stageReg[1:0], strobeN};
   end

   assign strobeS = stageReg[1];
   assign fall    = stageReg[2] & ~stageReg[1];
   assign rise    = ~stageReg[2] & stageReg[1];

endmodule

// File: rtl/para_bus_sync.sv
// Clocked DSP parallel-bus slave: control/LED/status registers plus read-only
// incremental and absolute encoder channels. PARABUS_SNAPSHOT_EN enables
// the high-word shadow latches for atomic 32-bit reads.
module para_bus_sync
   import para_bus_pkg::*;
#(
   parameter int AW    = 8,
   parameter int DW    = 16,
   parameter int N_INC = 7,
   parameter int N_ABS = 16
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [AW-1:0]      dsp_add,
   inout  wire  [DW-1:0]      dsp_data,
   input  logic               wr_n,
   input  logic               rd_n,
   input  logic               cs0_n,
   input  logic [N_INC*32-1:0] inc_encoder,
   input  logic [N_ABS*DW-1:0] abs_encoder,
   output logic [DW-1:0]      control,
   output logic               inc_encoder_rd,
   output logic [3:0]         led,
   output logic               bus_collision
);

   logic [2:0] strobeIn, strobeS, strobeFall, strobeRise;
   assign strobeIn = {cs0_n, rd_n, wr_n};

   genvar gi;
   for (gi = 0; gi < 3; gi++) begin : gSync
      strobe_sync uSync (
         .clk     (clk),
         .rst_n   (rst_n),
         .strobeN (strobeIn[gi]),
         .strobeS (strobeS[gi]),
         .fall    (strobeFall[gi]),
         .rise    (strobeRise[gi])
      );
   end

   logic wrS, rdS, csS, wrFall, wrRise, rdFall;
   assign wrS    = strobeS[0];
   assign rdS    = strobeS[1];
   assign csS    = strobeS[2];
   assign wrFall = strobeFall[0];
   assign rdFall = strobeFall[1];
   assign wrRise = strobeRise[0];

   logic unusedEdges;
   assign unusedEdges = &{strobeRise[2:1], strobeFall[2], 1'b0};

   logic [AW-1:0] addQ;
   logic [DW-1:0] dinQ;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addQ <= '0;
         dinQ <= '0;
      end else begin
         addQ <= dsp_add;
         dinQ <= dsp_data;
      end
   end

   // Fixed-size channel tables; slots beyond the configured count read as zero.
   logic [DW-1:0] incLo  [INC_SLOTS];
   logic [DW-1:0] incHi  [INC_SLOTS];
   logic [DW-1:0] absWord[ABS_SLOTS];

   for (gi = 0; gi < INC_SLOTS; gi++) begin : gInc
      if (gi < N_INC) begin : gLive
         assign incLo[gi] = DW'(inc_encoder[32*gi +: 16]);
         assign incHi[gi] = DW'(inc_encoder[32*gi+16 +: 16]);
      end else begin : gZero
         assign incLo[gi] = '0;
         assign incHi[gi] = '0;
      end
   end

   for (gi = 0; gi < ABS_SLOTS; gi++) begin : gAbs
      if (gi < N_ABS) begin : gLive
         assign absWord[gi] = abs_encoder[DW*gi +: DW];
      end else begin : gZero
         assign absWord[gi] = '0;
      end
   end

   busState_t stateReg, stateNext;
   logic controlRegBit0Unused;
   logic [DW-1:0] controlReg, rdReg, rdNext, wrDataReg;
   logic [AW-1:0] wrAddReg;
   logic [3:0]    ledReg;
   logic          collisionReg, csPrevReg;
   logic          collisionNow, readEntry, writeCapture, writeCommit, busDrive;
   logic [31:0]   addVal, wrAddVal;

   assign controlRegBit0Unused = 1'b0;
   assign addVal   = 32'(addQ);
   assign wrAddVal = 32'(wrAddReg);
   assign collisionNow = ~rdS & ~wrS & ~csS;

   always_ff @(posedge clk) begin
      if (!rst_n) stateReg <= IDLE;
      else        stateReg <= stateNext;
   end

   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         IDLE: begin
            if (collisionNow)          stateNext = IDLE;
            else if (rdFall && !csS)   stateNext = READ;
            else if (wrFall && !csS)   stateNext = WRITE;
         end
         READ:    if (collisionNow || rdS || csS) stateNext = IDLE;
         WRITE:   if (collisionNow || wrRise)     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      busDrive     = (stateReg == READ);
      readEntry    = (stateReg == IDLE) && (stateNext == READ);
      writeCapture = (stateReg == WRITE);
      writeCommit  = (stateReg == WRITE) && wrRise && !csPrevReg && !collisionNow;
   end

`ifdef PARABUS_SNAPSHOT_EN
   logic [DW-1:0] shadowReg[INC_SLOTS];

   // High word latched at the same edge that returns the low word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < INC_SLOTS; i++) shadowReg[i] <= '0;
      end else if (readEntry && addVal >= INC_LO_BASE && addVal < INC_LO_BASE + INC_SLOTS) begin
         shadowReg[addVal[2:0]] <= incHi[addVal[2:0]];
      end
   end
`endif

   always_comb begin
      rdNext = '0;
      if (addVal == CONTROL_ADD) begin
         rdNext = controlReg;
      end else if (addVal == LED_ADD) begin
         rdNext[3:0] = ledReg;
      end else if (addVal == STATUS_ADD) begin
         rdNext[STATUS_COLLISION_BIT] = collisionReg;
      end else if (addVal >= INC_LO_BASE && addVal < INC_LO_BASE + INC_SLOTS) begin
         rdNext = incLo[addVal[2:0]];
      end else if (addVal >= INC_HI_BASE && addVal < INC_HI_BASE + INC_SLOTS) begin
`ifdef PARABUS_SNAPSHOT_EN
         rdNext = shadowReg[addVal[2:0]];
`else
         rdNext = incHi[addVal[2:0]];
`endif
      end else if (addVal >= ABS_BASE && addVal < ABS_BASE + ABS_SLOTS) begin
         rdNext = absWord[addVal[3:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         controlReg   <= '0;
         ledReg       <= '0;
         collisionReg <= 1'b0;
         rdReg        <= '0;
         wrAddReg     <= '0;
         wrDataReg    <= '0;
         csPrevReg    <= 1'b1;
      end else begin
         csPrevReg <= csS;
         if (readEntry) rdReg <= rdNext;
         if (writeCapture) begin
            wrAddReg  <= addQ;
            wrDataReg <= dinQ;
         end
         if (writeCommit) begin
            if (wrAddVal == CONTROL_ADD)   controlReg <= wrDataReg;
            else if (wrAddVal == LED_ADD)  ledReg     <= wrDataReg[3:0];
            else if (wrAddVal == STATUS_ADD && wrDataReg[STATUS_COLLISION_BIT])
               collisionReg <= 1'b0;
         end
         // Setting wins over a clear in the same cycle.
         if (collisionNow) collisionReg <= 1'b1;
      end
   end

   assign dsp_data       = busDrive ? rdReg : {DW{1'bz}};
   assign control        = controlReg;
   assign inc_encoder_rd = controlReg[0] | controlRegBit0Unused;
   assign led            = ledReg;
   assign bus_collision  = collisionReg;

endmodule

// File: tb/tb_para_bus_sync.sv
// Scoreboard bench for para_bus_sync: a default instance plus an N_ABS=8
// instance share the strobes; each has its own pulled-up data bus.
module tb_para_bus_sync;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic [7:0]  dspAdd = '0;
   logic        wrN = 1'b1, rdN = 1'b1, csN = 1'b1;
   logic [15:0] tbData = '0;
   logic        tbDrive = 1'b0;
   logic [7*32-1:0]  incEnc = '0;
   logic [16*16-1:0] absEnc = '0;
   wire  [15:0] dspData, dspData8;

   logic [15:0] control, control8;
   logic        incRd, incRd8, collision, collision8;
   logic [3:0]  led, led8;

   int checkCount = 0;
   int failCount  = 0;
   logic [15:0] expQ[$];
   logic [15:0] expQ8[$];

   always #5 clk = ~clk;

   assign dspData  = tbDrive ? tbData : 16'hzzzz;
   assign dspData8 = tbDrive ? tbData : 16'hzzzz;

   for (genvar gi = 0; gi < 16; gi++) begin : gPull
      pullup (dspData[gi]);
      pullup (dspData8[gi]);
   end

   para_bus_sync dut (
      .clk(clk), .rst_n(rstN), .dsp_add(dspAdd), .dsp_data(dspData),
      .wr_n(wrN), .rd_n(rdN), .cs0_n(csN),
      .inc_encoder(incEnc), .abs_encoder(absEnc),
      .control(control), .inc_encoder_rd(incRd), .led(led),
      .bus_collision(collision)
   );

   para_bus_sync #(.N_ABS(8)) dut8 (
      .clk(clk), .rst_n(rstN), .dsp_add(dspAdd), .dsp_data(dspData8),
      .wr_n(wrN), .rd_n(rdN), .cs0_n(csN),
      .inc_encoder(incEnc), .abs_encoder(absEnc[8*16-1:0]),
      .control(control8), .inc_encoder_rd(incRd8), .led(led8),
      .bus_collision(collision8)
   );

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic busRead(input logic [7:0] addr, input logic [15:0] exp, input logic [15:0] exp8);
      @(negedge clk) dspAdd = addr;
      @(negedge clk) begin csN = 1'b0; rdN = 1'b0; end
      expQ.push_back(exp);
      expQ8.push_back(exp8);
      repeat (6) @(negedge clk);
      checkVal($sformatf("rd_%02h", addr), dspData, expQ.pop_front());
      checkVal($sformatf("rd8_%02h", addr), dspData8, expQ8.pop_front());
      rdN = 1'b1; csN = 1'b1;
      repeat (4) @(negedge clk);
      checkVal($sformatf("release_%02h", addr), dspData, 16'hFFFF);
   endtask

   task automatic busWrite(input logic [7:0] addr, input logic [15:0] data);
      @(negedge clk) begin dspAdd = addr; tbData = data; tbDrive = 1'b1; end
      @(negedge clk) begin csN = 1'b0; wrN = 1'b0; end
      repeat (5) @(negedge clk);
      wrN = 1'b1;
      @(negedge clk) begin csN = 1'b1; tbDrive = 1'b0; end
      repeat (4) @(negedge clk);
      $display("wr   %02h <= 0x%04h", addr, data);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] hiExp, hiAfterRst;
`ifdef PARABUS_SNAPSHOT_EN
      hiExp = 16'h1234;
      hiAfterRst = 16'h0000;
`else
      hiExp = 16'h1235;
      hiAfterRst = 16'h1235;
`endif
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      repeat (2) @(negedge clk);
      checkVal("rst_control", control, 16'h0000);
      checkVal("rst_led", led, 4'h0);
      checkVal("rst_incrd", incRd, 1'b0);
      checkVal("rst_collision", collision, 1'b0);
      checkVal("rst_bus", dspData, 16'hFFFF);

      busRead(8'h00, 16'h0000, 16'h0000);
      busRead(8'h01, 16'h0000, 16'h0000);
      busRead(8'h02, 16'h0000, 16'h0000);

      busWrite(8'h00, 16'h0005);
      busWrite(8'h01, 16'h000A);
      checkVal("wr_control", control, 16'h0005);
      checkVal("wr_incrd", incRd, 1'b1);
      checkVal("wr_led", led, 4'hA);
      busRead(8'h00, 16'h0005, 16'h0005);
      busRead(8'h01, 16'h000A, 16'h000A);

      incEnc[2*32 +: 32] = 32'h1234_FFFF;
      busRead(8'h12, 16'hFFFF, 16'hFFFF);
      incEnc[2*32 +: 32] = 32'h1235_0000;
      busRead(8'h1A, hiExp, hiExp);
      busRead(8'h17, 16'h0000, 16'h0000);
      busRead(8'h1F, 16'h0000, 16'h0000);

      absEnc[15*16 +: 16] = 16'hBEEF;
      absEnc[3*16 +: 16]  = 16'h0123;
      busRead(8'h2F, 16'hBEEF, 16'h0000);
      busRead(8'h23, 16'h0123, 16'h0123);
      busRead(8'h05, 16'h0000, 16'h0000);

      // Simultaneous read and write strobes.
      @(negedge clk) begin dspAdd = 8'h00; tbData = 16'hFFFF; tbDrive = 1'b1; end
      @(negedge clk) begin csN = 1'b0; rdN = 1'b0; wrN = 1'b0; end
      repeat (6) @(negedge clk);
      rdN = 1'b1; wrN = 1'b1;
      @(negedge clk) begin csN = 1'b1; tbDrive = 1'b0; end
      repeat (4) @(negedge clk);
      checkVal("coll_flag", collision, 1'b1);
      checkVal("coll_control", control, 16'h0005);
      checkVal("coll_led", led, 4'hA);
      busRead(8'h02, 16'h0001, 16'h0001);
      busWrite(8'h02, 16'h0001);
      checkVal("coll_clear", collision, 1'b0);
      busRead(8'h02, 16'h0000, 16'h0000);

      // Reset two cycles into a write.
      @(negedge clk) begin dspAdd = 8'h00; tbData = 16'h00FF; tbDrive = 1'b1; end
      @(negedge clk) begin csN = 1'b0; wrN = 1'b0; end
      repeat (2) @(negedge clk);
      rstN = 1'b0;
      repeat (3) @(negedge clk);
      wrN = 1'b1;
      @(negedge clk) begin csN = 1'b1; tbDrive = 1'b0; end
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      repeat (4) @(negedge clk);
      checkVal("rstwr_control", control, 16'h0000);
      checkVal("rstwr_led", led, 4'h0);

      // Reset in the middle of a read.
      busWrite(8'h01, 16'h0003);
      @(negedge clk) dspAdd = 8'h01;
      @(negedge clk) begin csN = 1'b0; rdN = 1'b0; end
      expQ.push_back(16'h0003);
      expQ8.push_back(16'h0003);
      repeat (6) @(negedge clk);
      checkVal("rstrd_data", dspData, expQ.pop_front());
      checkVal("rstrd_data8", dspData8, expQ8.pop_front());
      rstN = 1'b0;
      @(negedge clk);
      checkVal("rstrd_release", dspData, 16'hFFFF);
      rdN = 1'b1; csN = 1'b1;
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      repeat (4) @(negedge clk);
      checkVal("rstrd_led", led, 4'h0);
      busRead(8'h1A, hiAfterRst, hiAfterRst);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
